// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: states, instruction fields,
// ALU operation codes, fault codes and the bundled control-output record.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        I_ALU  = 3'd0,
        I_LW   = 3'd1,
        I_SW   = 3'd2,
        I_BEQZ = 3'd3,
        I_JMP  = 3'd4
    } instr_e;

    localparam logic [5:0] OP_ALU  = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_JMP  = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [10:0] FN_ADD = 11'h020;
    localparam logic [10:0] FN_SUB = 11'h022;
    localparam logic [10:0] FN_AND = 11'h024;
    localparam logic [10:0] FN_OR  = 11'h025;
    localparam logic [10:0] FN_XOR = 11'h026;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       pc_enable;
        logic       pc_select_enable;
        logic       npc_enable;
        logic       ir_enable;
        logic       reg_write_enable;
        logic       writeback_select_enable;
        logic       mux1_select_enable;
        logic       mux2_select_enable;
        logic       mem_write_enable;
        logic       mem_data_select_enable;
        logic       halted;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/wait_timer.sv
// Wait-state counter for the memory watchdog: counts ticks, clears on demand,
// and flags when the count sits on the last permitted wait cycle.
module wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic tick_i,
    output logic expired_o
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'((LIMIT == 0) ? 0 : LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // LIMIT of zero disables the watchdog entirely.
    assign expired_o = (LIMIT != 0) && (count_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, wait-state watchdog, sticky HALT trapping and a retire counter.
module multicycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPW     = 6,
    parameter int unsigned FUNCW   = 11,
    parameter int unsigned ALUOPW  = 3,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPW-1:0]    opcode,
    input  logic [FUNCW-1:0]  alu_func,
    input  logic              equal,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              pc_enable,
    output logic              pc_select_enable,
    output logic              npc_enable,
    output logic              ir_enable,
    output logic              reg_write_enable,
    output logic              writeback_select_enable,
    output logic              mux1_select_enable,
    output logic              mux2_select_enable,
    output logic [ALUOPW-1:0] alu_op,
    output logic              mem_write_enable,
    output logic              mem_data_select_enable,
    output logic [2:0]        state,
    output logic              halted,
    output logic [1:0]        fault,
    output logic [CNT_W-1:0]  retired_cnt
);

    state_e           state_q, state_d;
    instr_e           instr_q, instr_d;
    logic [2:0]       aluop_q, aluop_d;
    logic [1:0]       fault_q, fault_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             waiting;
    logic             wt_expired;
    ctrl_t            ctrl_c;
    ctrl_t            ctrl;

    wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clear_i   (!waiting || wt_expired),
        .tick_i    (waiting),
        .expired_o (wt_expired)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        aluop_d = aluop_q;
        fault_d = fault_q;
        retire  = 1'b0;
        waiting = 1'b0;
        ctrl_c  = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_c.imem_req = 1'b1;
                if (imem_ready) begin
                    ctrl_c.ir_enable  = 1'b1;
                    ctrl_c.npc_enable = 1'b1;
                    ctrl_c.pc_enable  = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    waiting = 1'b1;
                    if (wt_expired) begin
                        state_d = S_HALT;
                        fault_d = FAULT_TIMEOUT;
                    end
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                aluop_d = ALU_ADD;
                case (opcode)
                    OPW'(OP_ALU): begin
                        instr_d = I_ALU;
                        case (alu_func)
                            FUNCW'(FN_ADD): aluop_d = ALU_ADD;
                            FUNCW'(FN_SUB): aluop_d = ALU_SUB;
                            FUNCW'(FN_AND): aluop_d = ALU_AND;
                            FUNCW'(FN_OR):  aluop_d = ALU_OR;
                            FUNCW'(FN_XOR): aluop_d = ALU_XOR;
                            default: begin
                                state_d = S_HALT;
                                fault_d = FAULT_ILLEGAL;
                            end
                        endcase
                    end
                    OPW'(OP_LW):   instr_d = I_LW;
                    OPW'(OP_SW):   instr_d = I_SW;
                    OPW'(OP_BEQZ): instr_d = I_BEQZ;
                    OPW'(OP_JMP):  instr_d = I_JMP;
                    OPW'(OP_HALT): begin
                        state_d = S_HALT;
                        fault_d = FAULT_NONE;
                    end
                    default: begin
                        state_d = S_HALT;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: begin
                ctrl_c.alu_op = aluop_q;
                case (instr_q)
                    I_ALU: begin
                        ctrl_c.mux1_select_enable = 1'b1;
                        state_d = S_WB;
                    end
                    I_LW, I_SW: state_d = S_MEM;
                    I_BEQZ: begin
                        ctrl_c.mux2_select_enable = 1'b1;
                        ctrl_c.pc_enable          = equal;
                        ctrl_c.pc_select_enable   = equal;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        ctrl_c.mux2_select_enable = 1'b1;
                        ctrl_c.pc_enable          = 1'b1;
                        ctrl_c.pc_select_enable   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                ctrl_c.dmem_req         = 1'b1;
                ctrl_c.mem_write_enable = (instr_q == I_SW);
                if (dmem_ready) begin
                    retire  = (instr_q == I_SW);
                    state_d = (instr_q == I_SW) ? S_FETCH : S_WB;
                end else begin
                    waiting = 1'b1;
                    if (wt_expired) begin
                        state_d = S_HALT;
                        fault_d = FAULT_TIMEOUT;
                    end
                end
            end
            S_WB: begin
                ctrl_c.reg_write_enable        = 1'b1;
                ctrl_c.writeback_select_enable = (instr_q == I_ALU);
                ctrl_c.mem_data_select_enable  = (instr_q == I_ALU);
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: ctrl_c.halted = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            instr_q   <= I_ALU;
            aluop_q   <= '0;
            fault_q   <= FAULT_NONE;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            aluop_q <= aluop_d;
            fault_q <= fault_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Gating with reset makes requests drop the instant reset asserts, not at the next edge.
    assign ctrl = reset ? ctrl_c : '0;

    assign imem_req                = ctrl.imem_req;
    assign dmem_req                = ctrl.dmem_req;
    assign pc_enable               = ctrl.pc_enable;
    assign pc_select_enable        = ctrl.pc_select_enable;
    assign npc_enable              = ctrl.npc_enable;
    assign ir_enable               = ctrl.ir_enable;
    assign reg_write_enable        = ctrl.reg_write_enable;
    assign writeback_select_enable = ctrl.writeback_select_enable;
    assign mux1_select_enable      = ctrl.mux1_select_enable;
    assign mux2_select_enable      = ctrl.mux2_select_enable;
    assign alu_op                  = ALUOPW'(ctrl.alu_op);
    assign mem_write_enable        = ctrl.mem_write_enable;
    assign mem_data_select_enable  = ctrl.mem_data_select_enable;
    assign halted                  = ctrl.halted;
    assign state                   = state_q;
    assign fault                   = fault_q;
    assign retired_cnt             = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-instruction expected traces
// built from the instruction rules, driven from a vector table and random stream.
`timescale 1ns/1ps
module tb_multicycle_sequencer;

    localparam int unsigned TO = 16;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    opcode;
    logic [10:0]   alu_func;
    logic          equal, imem_ready, dmem_ready;
    logic          imem_req, dmem_req, pc_enable, pc_select_enable, npc_enable, ir_enable;
    logic          reg_write_enable, writeback_select_enable, mux1_select_enable, mux2_select_enable;
    logic [2:0]    alu_op;
    logic          mem_write_enable, mem_data_select_enable;
    logic [2:0]    state;
    logic          halted;
    logic [1:0]    fault;
    logic [CW-1:0] retired_cnt;

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .OPW(6), .FUNCW(11), .ALUOPW(3), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_func(alu_func), .equal(equal),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
        .pc_enable(pc_enable), .pc_select_enable(pc_select_enable), .npc_enable(npc_enable),
        .ir_enable(ir_enable), .reg_write_enable(reg_write_enable),
        .writeback_select_enable(writeback_select_enable), .mux1_select_enable(mux1_select_enable),
        .mux2_select_enable(mux2_select_enable), .alu_op(alu_op), .mem_write_enable(mem_write_enable),
        .mem_data_select_enable(mem_data_select_enable), .state(state), .halted(halted),
        .fault(fault), .retired_cnt(retired_cnt)
    );

    typedef struct packed {
        logic [2:0] st;
        logic imem, dmem, pce, pcs, npc, ir, rw, wbs, m1, m2;
        logic [2:0] aop;
        logic mwe, mds, hlt;
        logic [1:0] flt;
    } obs_t;

    typedef struct {
        logic [5:0]  op;
        logic [10:0] fn;
        logic        eq;
        int          fw, mw;
        logic [2:0]  e_aop;
        logic        e_pcs;
        int          e_cpi;
        logic        e_halt;
        logic [1:0]  e_flt;
    } vec_t;

    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQZ = 3, K_JMP = 4, K_HALTOP = 5, K_ILL = 6;

    int checks = 0;
    int failures = 0;
    int exp_ret = 0;

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.imem = imem_req; o.dmem = dmem_req; o.pce = pc_enable;
        o.pcs = pc_select_enable; o.npc = npc_enable; o.ir = ir_enable; o.rw = reg_write_enable;
        o.wbs = writeback_select_enable; o.m1 = mux1_select_enable; o.m2 = mux2_select_enable;
        o.aop = alu_op; o.mwe = mem_write_enable; o.mds = mem_data_select_enable;
        o.hlt = halted; o.flt = fault;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int kind_of(input logic [5:0] op, input logic [10:0] fn);
        case (op)
            6'h00:   return (fn inside {11'h020, 11'h022, 11'h024, 11'h025, 11'h026}) ? K_ALU : K_ILL;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQZ;
            6'h02:   return K_JMP;
            6'h3F:   return K_HALTOP;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] alu_code(input logic [10:0] fn);
        case (fn)
            11'h022: return 3'd1;
            11'h024: return 3'd2;
            11'h025: return 3'd3;
            11'h026: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; equal = 1'b0;
        @(negedge clk);
        check_obs("reset_outputs", sample(), '0);
        check_val("reset_retired", int'(retired_cnt), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_ret = 0;
    endtask

    // Builds the expected per-cycle trace for one instruction, drives the ready
    // schedule and compares every cycle; leaves the DUT in FETCH or HALT.
    task automatic run_instr(input logic [5:0] op, input logic [10:0] fn, input logic eq,
                             input int fw, input int mw, output obs_t exec_o, output int cpi);
        obs_t exp_q[$];
        bit   ir_q[$];
        bit   dr_q[$];
        obs_t o;
        int   k, exec_idx, n_work;
        bit   halts;
        logic [1:0] hf;
        k = kind_of(op, fn);
        halts = 0; hf = 2'b00; exec_idx = -1; exec_o = '0; cpi = 0;
        for (int i = 0; i < fw && i < int'(TO); i++) begin
            o = '0; o.imem = 1; exp_q.push_back(o); ir_q.push_back(0); dr_q.push_back(1'($urandom));
        end
        if (fw >= int'(TO)) begin
            halts = 1; hf = 2'b10;
        end else begin
            o = '0; o.imem = 1; o.pce = 1; o.npc = 1; o.ir = 1;
            exp_q.push_back(o); ir_q.push_back(1); dr_q.push_back(1'($urandom));
            o = '0; o.st = 3'd1;
            exp_q.push_back(o); ir_q.push_back(1'($urandom)); dr_q.push_back(1'($urandom));
            if (k >= K_HALTOP) begin
                halts = 1; hf = (k == K_HALTOP) ? 2'b00 : 2'b01;
            end else begin
                o = '0; o.st = 3'd2;
                if (k == K_ALU) begin o.m1 = 1; o.aop = alu_code(fn); end
                if (k == K_BEQZ) begin o.m2 = 1; o.pce = eq; o.pcs = eq; end
                if (k == K_JMP) begin o.m2 = 1; o.pce = 1; o.pcs = 1; end
                exp_q.push_back(o); ir_q.push_back(1'($urandom)); dr_q.push_back(1'($urandom));
                exec_idx = exp_q.size() - 1;
                if (k == K_LW || k == K_SW) begin
                    o = '0; o.st = 3'd3; o.dmem = 1; o.mwe = (k == K_SW);
                    for (int i = 0; i < mw && i < int'(TO); i++) begin
                        exp_q.push_back(o); ir_q.push_back(1'($urandom)); dr_q.push_back(0);
                    end
                    if (mw >= int'(TO)) begin
                        halts = 1; hf = 2'b10;
                    end else begin
                        exp_q.push_back(o); ir_q.push_back(1'($urandom)); dr_q.push_back(1);
                    end
                end
                if (!halts && (k == K_ALU || k == K_LW)) begin
                    o = '0; o.st = 3'd4; o.rw = 1; o.wbs = (k == K_ALU); o.mds = (k == K_ALU);
                    exp_q.push_back(o); ir_q.push_back(1'($urandom)); dr_q.push_back(1'($urandom));
                end
            end
        end
        n_work = exp_q.size();
        if (halts) begin
            for (int i = 0; i < 20; i++) begin
                o = '0; o.st = 3'd7; o.hlt = 1; o.flt = hf;
                exp_q.push_back(o); ir_q.push_back(1'($urandom)); dr_q.push_back(1'($urandom));
            end
        end
        opcode = op; alu_func = fn; equal = eq;
        for (int i = 0; i < exp_q.size(); i++) begin
            imem_ready = ir_q[i]; dmem_ready = dr_q[i];
            @(negedge clk);
            if (i == exec_idx) exec_o = sample();
            check_obs($sformatf("cycle%0d_op%h", i, op), sample(), exp_q[i]);
            @(posedge clk); #1;
        end
        if (!halts) begin
            exp_ret = (exp_ret + 1) % (1 << CW);
            cpi = n_work + ((state == 3'd0) ? 0 : 100);
        end
        check_val("retired", int'(retired_cnt), exp_ret);
    endtask

    vec_t tbl[18];
    logic [5:0]  op_list[5];
    logic [10:0] fn_list[5];

    initial begin
        obs_t ex;
        int   cpi;
        int   n;
        reset = 1'b0; opcode = '0; alu_func = '0; equal = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;

        tbl[0]  = '{6'h00, 11'h020, 1'b0, 0, 0, 3'd0, 1'b0, 4, 1'b0, 2'b00};
        tbl[1]  = '{6'h00, 11'h022, 1'b1, 1, 0, 3'd1, 1'b0, 5, 1'b0, 2'b00};
        tbl[2]  = '{6'h00, 11'h024, 1'b0, 0, 0, 3'd2, 1'b0, 4, 1'b0, 2'b00};
        tbl[3]  = '{6'h00, 11'h025, 1'b0, 2, 0, 3'd3, 1'b0, 6, 1'b0, 2'b00};
        tbl[4]  = '{6'h00, 11'h026, 1'b1, 0, 0, 3'd4, 1'b0, 4, 1'b0, 2'b00};
        tbl[5]  = '{6'h23, 11'h123, 1'b0, 0, 3, 3'd0, 1'b0, 8, 1'b0, 2'b00};
        tbl[6]  = '{6'h2B, 11'h7FF, 1'b1, 0, 0, 3'd0, 1'b0, 4, 1'b0, 2'b00};
        tbl[7]  = '{6'h2B, 11'h000, 1'b0, 1, 2, 3'd0, 1'b0, 7, 1'b0, 2'b00};
        tbl[8]  = '{6'h04, 11'h020, 1'b0, 0, 0, 3'd0, 1'b0, 3, 1'b0, 2'b00};
        tbl[9]  = '{6'h04, 11'h020, 1'b1, 0, 0, 3'd0, 1'b1, 3, 1'b0, 2'b00};
        tbl[10] = '{6'h02, 11'h000, 1'b0, 0, 0, 3'd0, 1'b1, 3, 1'b0, 2'b00};
        tbl[11] = '{6'h23, 11'h000, 1'b0, 15, 15, 3'd0, 1'b0, 35, 1'b0, 2'b00};
        tbl[12] = '{6'h23, 11'h000, 1'b0, 0, 0, 3'd0, 1'b0, 5, 1'b0, 2'b00};
        tbl[13] = '{6'h00, 11'h021, 1'b0, 0, 0, 3'd0, 1'b0, 0, 1'b1, 2'b01};
        tbl[14] = '{6'h15, 11'h020, 1'b0, 0, 0, 3'd0, 1'b0, 0, 1'b1, 2'b01};
        tbl[15] = '{6'h3F, 11'h020, 1'b0, 0, 0, 3'd0, 1'b0, 0, 1'b1, 2'b00};
        tbl[16] = '{6'h00, 11'h020, 1'b0, 16, 0, 3'd0, 1'b0, 0, 1'b1, 2'b10};
        tbl[17] = '{6'h23, 11'h000, 1'b0, 0, 16, 3'd0, 1'b0, 0, 1'b1, 2'b10};

        apply_reset();
        for (int t = 0; t < 18; t++) begin
            run_instr(tbl[t].op, tbl[t].fn, tbl[t].eq, tbl[t].fw, tbl[t].mw, ex, cpi);
            if (tbl[t].e_halt) begin
                check_val($sformatf("vec%0d_fault", t), int'(fault), int'(tbl[t].e_flt));
                check_val($sformatf("vec%0d_halted", t), int'(halted), 1);
                apply_reset();
            end else begin
                check_val($sformatf("vec%0d_aluop", t), int'(ex.aop), int'(tbl[t].e_aop));
                check_val($sformatf("vec%0d_pcsel", t), int'(ex.pcs), int'(tbl[t].e_pcs));
                check_val($sformatf("vec%0d_cpi", t), cpi, tbl[t].e_cpi);
            end
        end

        // Random legal instruction stream; retired count wraps several times.
        op_list[0] = 6'h00; op_list[1] = 6'h23; op_list[2] = 6'h2B; op_list[3] = 6'h04; op_list[4] = 6'h02;
        fn_list[0] = 11'h020; fn_list[1] = 11'h022; fn_list[2] = 11'h024; fn_list[3] = 11'h025; fn_list[4] = 11'h026;
        for (int r = 0; r < 60; r++) begin
            logic [5:0]  op;
            logic [10:0] fn;
            int fw, mw;
            op = op_list[$urandom_range(0, 4)];
            fn = (op == 6'h00) ? fn_list[$urandom_range(0, 4)] : 11'($urandom);
            fw = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
            run_instr(op, fn, 1'($urandom), fw, mw, ex, cpi);
        end

        // Reset asserted between clock edges during a stalled SW access.
        apply_reset();
        run_instr(6'h00, 11'h020, 1'b0, 0, 0, ex, cpi);
        opcode = 6'h2B; imem_ready = 1'b1; dmem_ready = 1'b0;
        n = 0;
        while (state != 3'd3 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("sw_reach_mem", int'(state), 3);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("sw_mwe_held", int'(mem_write_enable), 1);
        check_val("sw_dmem_req_held", int'(dmem_req), 1);
        #2;
        reset = 1'b0;
        #1;
        check_val("midreset_dmem_req", int'(dmem_req), 0);
        check_val("midreset_mwe", int'(mem_write_enable), 0);
        check_val("midreset_state", int'(state), 0);
        check_val("midreset_retired", int'(retired_cnt), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
